// File: rtl/snn_pkg.sv
// Shared definitions for the SNN layer chain: default widths, address sizing,
// the spike bundle packing used by the layer input FIFOs and encoder states.
package snn_pkg;

    localparam int FEAT_W_DEF       = 8;
    localparam int TIME_W_DEF       = 32;
    localparam int SPIKE_ADDR_W_DEF = 6;

    // Address width for n entries, never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    typedef struct packed {
        logic                           last;
        logic signed [TIME_W_DEF-1:0]   spike_time;
        logic [SPIKE_ADDR_W_DEF-1:0]    addr;
    } spike_bundle_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } enc_state_t;

endpackage

// File: rtl/snn_ttfs_time_calc.sv
// Time-to-first-spike mapping: larger feature values yield earlier spike times.
module snn_ttfs_time_calc
    import snn_pkg::*;
#(
    parameter int FEAT_W   = FEAT_W_DEF,
    parameter int TIME_W   = TIME_W_DEF,
    parameter int T_OFFSET = 0
) (
    input  logic [FEAT_W-1:0]        feat,
    output logic signed [TIME_W-1:0] spike_time
);

    // ~feat equals (2^FEAT_W-1) - feat, zero-extended so the sum stays non-negative.
    assign spike_time = TIME_W'(T_OFFSET) + $signed({{(TIME_W-FEAT_W){1'b0}}, ~feat});

endmodule

// File: rtl/snn_ttfs_spike_encoder.sv
// TTFS encoder: holds one feature vector and streams one spike per feature,
// ordered by ascending spike time (ties to the lowest address), on a valid/ack port.
module snn_ttfs_spike_encoder
    import snn_pkg::*;
#(
    parameter int IN_NEURONS = 64,
    parameter int FEAT_W     = FEAT_W_DEF,
    parameter int TIME_W     = TIME_W_DEF,
    parameter int T_OFFSET   = 0,
    localparam int ADDR_W    = clog2(IN_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_feat_we,
    input  logic [ADDR_W-1:0]        i_feat_addr,
    input  logic [FEAT_W-1:0]        i_feat_data,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_spike_valid,
    output logic                     o_last_spike,
    output logic signed [TIME_W-1:0] o_spike_time,
    output logic [ADDR_W-1:0]        o_spike_addr,
    input  logic                     i_spike_ack
);

    localparam int CNT_W = clog2(IN_NEURONS + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IN_NEURONS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_NEURONS - 1);

    enc_state_t                state;
    logic [FEAT_W-1:0]         feat [IN_NEURONS];
    logic [IN_NEURONS-1:0]     sent;
    logic [ADDR_W-1:0]         scan_idx;
    logic [CNT_W-1:0]          emit_cnt;
    logic [FEAT_W-1:0]         best_x;
    logic [ADDR_W-1:0]         best_addr;
    logic                      best_found;

    logic [FEAT_W-1:0]         cur_x;
    logic                      take;
    logic [FEAT_W-1:0]         sel_x;
    logic [ADDR_W-1:0]         sel_addr;
    logic signed [TIME_W-1:0]  sel_time;

    // Strict compare keeps the earlier (lower) address on ties; the found flag lets x=0 win.
    always_comb begin
        cur_x    = feat[scan_idx];
        take     = !sent[scan_idx] && (!best_found || (cur_x > best_x));
        sel_x    = take ? cur_x    : best_x;
        sel_addr = take ? scan_idx : best_addr;
    end

    snn_ttfs_time_calc #(
        .FEAT_W   (FEAT_W),
        .TIME_W   (TIME_W),
        .T_OFFSET (T_OFFSET)
    ) u_time_calc (
        .feat       (sel_x),
        .spike_time (sel_time)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN_NEURONS; i++) feat[i] <= '0;
        end else if (state == ST_IDLE && i_feat_we) begin
            feat[i_feat_addr] <= i_feat_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sent          <= '0;
            emit_cnt      <= '0;
            scan_idx      <= '0;
            best_x        <= '0;
            best_addr     <= '0;
            best_found    <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_spike_valid <= 1'b0;
            o_last_spike  <= 1'b0;
            o_spike_time  <= '0;
            o_spike_addr  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state      <= ST_SCAN;
                        sent       <= '0;
                        emit_cnt   <= '0;
                        scan_idx   <= '0;
                        best_found <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    best_x     <= sel_x;
                    best_addr  <= sel_addr;
                    best_found <= best_found | take;
                    if (scan_idx == LAST_IDX) begin
                        state         <= ST_EMIT;
                        o_spike_valid <= 1'b1;
                        o_spike_addr  <= sel_addr;
                        o_spike_time  <= sel_time;
                        o_last_spike  <= (emit_cnt == LAST_CNT);
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (i_spike_ack) begin
                        sent[o_spike_addr] <= 1'b1;
                        emit_cnt           <= emit_cnt + 1'b1;
                        o_spike_valid      <= 1'b0;
                        o_last_spike       <= 1'b0;
                        scan_idx           <= '0;
                        best_found         <= 1'b0;
                        if (emit_cnt == LAST_CNT) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_ttfs_spike_encoder.sv
// Scoreboard bench for the TTFS encoder: two instances (offset 0 and 100) share
// stimulus; a sort-based reference model predicts each spike stream.
module tb_snn_ttfs_spike_encoder;

    localparam int N    = 4;
    localparam int FW   = 8;
    localparam int TW   = 32;
    localparam int AW   = 2;
    localparam int OFF1 = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic we = 1'b0;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [FW-1:0] wdata = '0;

    logic busy0, done0, v0, last0;
    logic signed [TW-1:0] t0;
    logic [AW-1:0] a0;
    logic busy1, done1, v1, last1;
    logic signed [TW-1:0] t1;
    logic [AW-1:0] a1;

    snn_ttfs_spike_encoder #(.IN_NEURONS(N), .FEAT_W(FW), .TIME_W(TW), .T_OFFSET(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_feat_we(we), .i_feat_addr(waddr), .i_feat_data(wdata),
        .i_start(start), .o_busy(busy0), .o_done(done0), .o_spike_valid(v0),
        .o_last_spike(last0), .o_spike_time(t0), .o_spike_addr(a0), .i_spike_ack(ack)
    );

    snn_ttfs_spike_encoder #(.IN_NEURONS(N), .FEAT_W(FW), .TIME_W(TW), .T_OFFSET(OFF1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_feat_we(we), .i_feat_addr(waddr), .i_feat_data(wdata),
        .i_start(start), .o_busy(busy1), .o_done(done1), .o_spike_valid(v1),
        .o_last_spike(last1), .o_spike_time(t1), .o_spike_addr(a1), .i_spike_ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int x;
        bit last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   xfer0 = 0;
    int   ack_mode = 0;
    int   last_ev [2];
    bit   prev_v [2];
    bit   exp_done [2];
    bit   holding [2];
    logic signed [TW-1:0] held_t [2];
    logic [AW-1:0] held_a [2];
    int   model_feat [N];

    int f1 [N] = '{10, 200, 200, 0};
    int f_off [N] = '{255, 0, 128, 255};
    int f_eq [N] = '{7, 7, 7, 7};
    int f_zero [N] = '{0, 0, 0, 0};
    int f_rnd [N];

    task automatic checkOutput(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic flagFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout expected completion", name);
    endtask

    // Reference: sort by (spike time, address) and emit in that order.
    task automatic buildExpected();
        int keys[$];
        exp_t e;
        for (int i = 0; i < N; i++) keys.push_back((255 - model_feat[i]) * N + i);
        keys.sort();
        for (int k = 0; k < N; k++) begin
            e.addr = keys[k] % N;
            e.x    = 255 - keys[k] / N;
            e.last = (k == N - 1);
            q0.push_back(e);
            q1.push_back(e);
        end
    endtask

    task automatic monitorStep(input int w, input logic v, input logic lst, input logic signed [TW-1:0] t,
                               input logic [AW-1:0] a, input logic b, input logic d, input logic ak);
        exp_t e;
        int   off;
        bit   have;
        off = (w == 0) ? 0 : OFF1;
        if (exp_done[w]) begin
            checkOutput($sformatf("d%0d_done_pulse", w), d, 1);
            checkOutput($sformatf("d%0d_busy_at_done", w), b, 0);
            exp_done[w] = 1'b0;
        end else if (d) begin
            checkOutput($sformatf("d%0d_spurious_done", w), d, 0);
        end
        if (holding[w]) begin
            checkOutput($sformatf("d%0d_hold_valid", w), v, 1);
            checkOutput($sformatf("d%0d_hold_addr", w), a, held_a[w]);
            checkOutput($sformatf("d%0d_hold_time", w), t, held_t[w]);
            holding[w] = 1'b0;
        end
        if (v && !prev_v[w])
            checkOutput($sformatf("d%0d_latency", w), cyc - last_ev[w], N + 1);
        if (v && ak) begin
            have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                checkOutput($sformatf("d%0d_unexpected_spike", w), v, 0);
            end else begin
                e = (w == 0) ? q0.pop_front() : q1.pop_front();
                checkOutput($sformatf("d%0d_addr", w), a, e.addr);
                checkOutput($sformatf("d%0d_time", w), t, off + 255 - e.x);
                checkOutput($sformatf("d%0d_last", w), lst, e.last);
                if (e.last) exp_done[w] = 1'b1;
            end
            last_ev[w] = cyc;
            if (w == 0) xfer0++;
        end else if (v) begin
            holding[w] = 1'b1;
            held_a[w]  = a;
            held_t[w]  = t;
        end
        prev_v[w] = v;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int w = 0; w < 2; w++) begin
                prev_v[w]   = 1'b0;
                exp_done[w] = 1'b0;
                holding[w]  = 1'b0;
            end
        end else begin
            if (start && !busy0 && !done0) begin
                last_ev[0] = cyc;
                last_ev[1] = cyc;
            end
            monitorStep(0, v0, last0, t0, a0, busy0, done0, ack);
            monitorStep(1, v1, last1, t1, a1, busy1, done1, ack);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = 1'($urandom_range(0, 1));
                default: ack = 1'b0;
            endcase
        end
    end

    task automatic writeFeat(input int i, input int x);
        @(posedge clk);
        #1;
        we    = 1'b1;
        waddr = AW'(i);
        wdata = FW'(x);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic loadAndStart(input int f [N], input bit do_write, input int mode);
        if (do_write) begin
            for (int i = 0; i < N; i++) begin
                writeFeat(i, f[i]);
                model_feat[i] = f[i];
            end
        end
        buildExpected();
        ack_mode = mode;
        xfer0 = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && !busy0 && !busy1 && !done0 && !done1) return;
        end
        flagFail(name);
        q0.delete();
        q1.delete();
        ack_mode = 0;
    endtask

    task automatic applyStimulus(input int f [N], input bit do_write, input int mode, input int hold, input bit guard);
        loadAndStart(f, do_write, (hold > 0) ? 2 : mode);
        if (guard) begin
            we    = 1'b1;
            waddr = '0;
            wdata = 8'd255;
            start = 1'b1;
            @(posedge clk);
            #1;
            we    = 1'b0;
            start = 1'b0;
        end
        if (hold > 0) begin
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (v0) break;
            end
            repeat (hold) @(posedge clk);
            #1;
            ack_mode = mode;
        end
        waitIdle("run_timeout");
    endtask

    initial begin
        for (int i = 0; i < N; i++) model_feat[i] = 0;
        #2 rst_n = 1'b0;
        #3;
        checkOutput("rst_valid", v0, 0);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_done", done0, 0);
        checkOutput("rst_last", last0, 0);
        checkOutput("rst_time", t0, 0);
        checkOutput("rst_addr", a0, 0);
        checkOutput("rst_valid_off", v1, 0);
        checkOutput("rst_busy_off", busy1, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] ordering and ties");
        applyStimulus(f1, 1, 0, 0, 0);
        $display("[TB] backpressure");
        applyStimulus(f1, 0, 0, 7, 0);
        $display("[TB] busy guards");
        applyStimulus(f1, 0, 0, 0, 1);
        applyStimulus(f_off, 1, 1, 0, 0);
        $display("[TB] all equal");
        applyStimulus(f_eq, 1, 0, 0, 0);

        $display("[TB] reset mid-emit");
        for (int i = 0; i < N; i++) f_rnd[i] = int'($urandom_range(0, 255));
        loadAndStart(f_rnd, 1, 0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (xfer0 >= 2 && v0) break;
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", v0, 0);
        checkOutput("midrst_busy", busy0, 0);
        checkOutput("midrst_done", done0, 0);
        checkOutput("midrst_valid_off", v1, 0);
        checkOutput("midrst_busy_off", busy1, 0);
        q0.delete();
        q1.delete();
        for (int i = 0; i < N; i++) model_feat[i] = 0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(f_zero, 0, 1, 0, 0);
        applyStimulus(f_rnd, 1, 0, 0, 0);

        $display("[TB] random vectors");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++)
                f_rnd[i] = (r % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            applyStimulus(f_rnd, 1, 1, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
